// File: rtl/foursprite_pixel_sched_if.sv
// Shared sprite ROM port.
//   rom_addr : {sprite_id[1:0], row[3:0], col[3:0]}
//   rom_en   : read request, one cycle
//   rom_data : palette index, valid the cycle after rom_en
// master = scheduler side, slave = ROM side.
interface foursprite_pixel_sched_if;
    logic [9:0] rom_addr;
    logic       rom_en;
    logic [3:0] rom_data;

    modport master (output rom_addr, rom_en, input rom_data);
    modport slave  (input rom_addr, rom_en, output rom_data);
endinterface

// File: rtl/foursprite_pixel_sched.sv
// Four-sprite pixel scheduler: for one pixel, find which enabled sprites
// cover it, fetch their ROM texels in fixed priority order (sprite 0 first)
// and return the first opaque (nonzero) palette index, or background.
//   Clk, Reset_n         : clock, synchronous active-low reset
//   pix_start            : one-cycle request to resolve draw_x/draw_y
//   draw_x, draw_y       : pixel coordinate
//   spr_x, spr_y, spr_en : packed sprite corners (10 bits each) and enables
//   rom                  : shared sprite ROM port (master)
//   pal_index, pix_sprite, bg : result, held until the next result
//   pix_valid            : one-cycle result strobe
//   busy, overrun        : not idle / sticky "start while busy"
module foursprite_pixel_sched #(
    parameter int SPR_SIZE = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 pix_start,
    input  logic [9:0]           draw_x,
    input  logic [9:0]           draw_y,
    input  logic [39:0]          spr_x,
    input  logic [39:0]          spr_y,
    input  logic [3:0]           spr_en,
    foursprite_pixel_sched_if.master rom,
    output logic [3:0]           pal_index,
    output logic [1:0]           pix_sprite,
    output logic                 bg,
    output logic                 pix_valid,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic [2:0] {IDLE, HIT, FETCH, WAIT, DONE} state_t;

    state_t          state;
    logic [9:0]      dx_q, dy_q;
    logic [3:0][9:0] sx_q, sy_q;
    logic [3:0]      en_q;
    logic [3:0]      mask;
    logic [1:0]      cur;

    logic [3:0]      hit_c;
    logic [3:0]      mask_clr;
    logic [3:0]      nmask;
    logic [1:0]      nk;
    logic [9:0]      addr_c;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // 11-bit compares: a sprite at x=1008 still covers x=1023.
    for (genvar k = 0; k < 4; k++) begin : g_hit
        logic [10:0] px, py, lx, ly;
        assign px = {1'b0, dx_q};
        assign py = {1'b0, dy_q};
        assign lx = {1'b0, sx_q[k]};
        assign ly = {1'b0, sy_q[k]};
        assign hit_c[k] = en_q[k] &&
                          (px >= lx) && (px < lx + 11'(SPR_SIZE)) &&
                          (py >= ly) && (py < ly + 11'(SPR_SIZE));
    end

    // Next fetch target: from the fresh hit mask in HIT, or from the mask
    // with the current (transparent) sprite removed in WAIT.
    assign mask_clr = mask & ~(4'b0001 << cur);
    assign nmask    = (state == HIT) ? hit_c : mask_clr;
    assign nk       = lowest(nmask);
    assign addr_c   = {nk, 4'(dy_q - sy_q[nk]), 4'(dx_q - sx_q[nk])};

    assign busy = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state        <= IDLE;
            dx_q         <= '0;
            dy_q         <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            en_q         <= '0;
            mask         <= '0;
            cur          <= '0;
            rom.rom_en   <= 1'b0;
            rom.rom_addr <= '0;
            pal_index    <= '0;
            pix_sprite   <= '0;
            bg           <= 1'b1;
            pix_valid    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            if (pix_start && state != IDLE)
                overrun <= 1'b1;

            case (state)
                IDLE: if (pix_start) begin
                    dx_q  <= draw_x;
                    dy_q  <= draw_y;
                    sx_q  <= spr_x;
                    sy_q  <= spr_y;
                    en_q  <= spr_en;
                    state <= HIT;
                end
                HIT: begin
                    mask <= hit_c;
                    if (|hit_c) begin
                        cur          <= nk;
                        rom.rom_en   <= 1'b1;
                        rom.rom_addr <= addr_c;
                        state        <= FETCH;
                    end else begin
                        pal_index  <= '0;
                        pix_sprite <= '0;
                        bg         <= 1'b1;
                        pix_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                FETCH: begin
                    rom.rom_en <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (rom.rom_data != 4'd0) begin
                        pal_index  <= rom.rom_data;
                        pix_sprite <= cur;
                        bg         <= 1'b0;
                        pix_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        mask <= mask_clr;
                        if (|mask_clr) begin
                            cur          <= nk;
                            rom.rom_en   <= 1'b1;
                            rom.rom_addr <= addr_c;
                            state        <= FETCH;
                        end else begin
                            pal_index  <= '0;
                            pix_sprite <= '0;
                            bg         <= 1'b1;
                            pix_valid  <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
